// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM encoding, counter widths, watchdog limit.
// Pure definitions, no logic; imported by the hazard controller and its forwarding compare.
package pipe_pkg;

    localparam int REG_W    = 5;
    localparam int BUBBLE_W = 16;
    localparam int WAIT_W   = 8;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

endpackage

// File: rtl/fwd_match.sv
// Per-operand register compare: EX/MEM forward selects and load-use match.
// Purely combinational, zero latency; no flow control of its own.
module fwd_match
    import pipe_pkg::*;
(
    input  logic             use_rs,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_RegWrite,
    input  logic             ex_MemRead,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_RegWrite,
    output logic             fwd_ex,
    output logic             fwd_mem,
    output logic             load_use
);

    logic rs_live;

    // x0 is hardwired to zero, so it never needs forwarding or stalling
    assign rs_live  = use_rs && (rs != '0);
    assign fwd_ex   = rs_live && ex_RegWrite && !ex_MemRead && (ex_rd == rs);
    assign fwd_mem  = rs_live && mem_RegWrite && (mem_rd == rs) && !fwd_ex;
    assign load_use = rs_live && ex_MemRead && (ex_rd == rs);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use stall, branch flush, memory freeze.
// Controls are same-cycle combinational, state updates on the falling edge; mem_busy freezes everything.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_RegWrite,
    input  logic                id_MemRead,
    input  logic                branch_taken,
    input  logic                mem_busy,
    output logic                fwd_ex_1,
    output logic                fwd_mem_1,
    output logic                fwd_ex_2,
    output logic                fwd_mem_2,
    output logic                stall_if,
    output logic                flush_if,
    output logic                clear_id,
    output logic                freeze,
    output logic [1:0]          state,
    output logic [BUBBLE_W-1:0] bubble_cnt,
    output logic                mem_timeout
);

    state_t             state_q, state_nxt;
    logic [REG_W-1:0]   ex_rd, mem_rd;
    logic               ex_RegWrite, ex_MemRead, mem_RegWrite;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               fe1, fm1, lu1, fe2, fm2, lu2;
    logic               load_use;

    fwd_match u_fwd_rs1 (
        .use_rs       (id_use_rs1),
        .rs           (id_rs1),
        .ex_rd        (ex_rd),
        .ex_RegWrite  (ex_RegWrite),
        .ex_MemRead   (ex_MemRead),
        .mem_rd       (mem_rd),
        .mem_RegWrite (mem_RegWrite),
        .fwd_ex       (fe1),
        .fwd_mem      (fm1),
        .load_use     (lu1)
    );

    fwd_match u_fwd_rs2 (
        .use_rs       (id_use_rs2),
        .rs           (id_rs2),
        .ex_rd        (ex_rd),
        .ex_RegWrite  (ex_RegWrite),
        .ex_MemRead   (ex_MemRead),
        .mem_rd       (mem_rd),
        .mem_RegWrite (mem_RegWrite),
        .fwd_ex       (fe2),
        .fwd_mem      (fm2),
        .load_use     (lu2)
    );

    assign load_use  = id_valid && (lu1 || lu2);

    assign fwd_ex_1  = rst && fe1;
    assign fwd_mem_1 = rst && fm1;
    assign fwd_ex_2  = rst && fe2;
    assign fwd_mem_2 = rst && fm2;
    assign state     = state_q;

    // Priority: reset, then memory wait, then branch redirect, then load-use
    always_comb begin
        stall_if  = 1'b0;
        flush_if  = 1'b0;
        clear_id  = 1'b0;
        freeze    = 1'b0;
        state_nxt = ST_RUN;
        if (!rst) begin
            clear_id = 1'b1;
        end else if (mem_busy) begin
            freeze    = 1'b1;
            state_nxt = ST_MEMWAIT;
        end else if (branch_taken) begin
            flush_if  = 1'b1;
            clear_id  = 1'b1;
            state_nxt = ST_FLUSH;
        end else if (load_use) begin
            stall_if  = 1'b1;
            clear_id  = 1'b1;
            state_nxt = ST_LDSTALL;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            ex_rd        <= '0;
            ex_RegWrite  <= 1'b0;
            ex_MemRead   <= 1'b0;
            mem_rd       <= '0;
            mem_RegWrite <= 1'b0;
            bubble_cnt   <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (!freeze) begin
                if (clear_id || !id_valid) begin
                    ex_rd       <= '0;
                    ex_RegWrite <= 1'b0;
                    ex_MemRead  <= 1'b0;
                end else begin
                    ex_rd       <= id_rd;
                    ex_RegWrite <= id_RegWrite;
                    ex_MemRead  <= id_MemRead;
                end
                mem_rd       <= ex_rd;
                mem_RegWrite <= ex_RegWrite;
            end
            if (clear_id && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            // Watchdog trips on the edge that completes the limit-th consecutive wait cycle
            if (mem_busy) begin
                if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= (WAIT_LIMIT - 1'b1)) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: state moves on negedge, inputs driven at negedge+1, outputs sampled at posedge+1.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       br;
        logic       busy;
    } stim_t;

    typedef struct packed {
        logic        fe1;
        logic        fm1;
        logic        fe2;
        logic        fm2;
        logic        stall;
        logic        flush;
        logic        clr;
        logic        frz;
        logic [1:0]  st;
        logic        tmo;
        logic [15:0] bcnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic        id_RegWrite, id_MemRead;
    logic        branch_taken, mem_busy;
    logic        fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2;
    logic        stall_if, flush_if, clear_id, freeze;
    logic [1:0]  state;
    logic [15:0] bubble_cnt;
    logic        mem_timeout;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    obs_t  got_q[$];
    int    checks = 0;
    int    passed = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_RegWrite  (id_RegWrite),
        .id_MemRead   (id_MemRead),
        .branch_taken (branch_taken),
        .mem_busy     (mem_busy),
        .fwd_ex_1     (fwd_ex_1),
        .fwd_mem_1    (fwd_mem_1),
        .fwd_ex_2     (fwd_ex_2),
        .fwd_mem_2    (fwd_mem_2),
        .stall_if     (stall_if),
        .flush_if     (flush_if),
        .clear_id     (clear_id),
        .freeze       (freeze),
        .state        (state),
        .bubble_cnt   (bubble_cnt),
        .mem_timeout  (mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk_s(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                                   logic [4:0] rd, logic rw, logic mr, logic br, logic busy);
        stim_t s;
        s = '{v:v, rs1:rs1, u1:u1, rs2:rs2, u2:u2, rd:rd, rw:rw, mr:mr, br:br, busy:busy};
        return s;
    endfunction

    function automatic obs_t mk_e(logic fe1, logic fm1, logic fe2, logic fm2, logic stall, logic flush,
                                  logic clr, logic frz, logic [1:0] st, logic tmo, logic [15:0] bcnt);
        obs_t e;
        e = '{fe1:fe1, fm1:fm1, fe2:fe2, fm2:fm2, stall:stall, flush:flush,
              clr:clr, frz:frz, st:st, tmo:tmo, bcnt:bcnt};
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = '{fe1:fwd_ex_1, fm1:fwd_mem_1, fe2:fwd_ex_2, fm2:fwd_mem_2, stall:stall_if,
              flush:flush_if, clr:clear_id, frz:freeze, st:state, tmo:mem_timeout, bcnt:bubble_cnt};
        return o;
    endfunction

    task automatic apply(input stim_t s);
        id_valid     = s.v;
        id_rs1       = s.rs1;
        id_use_rs1   = s.u1;
        id_rs2       = s.rs2;
        id_use_rs2   = s.u2;
        id_rd        = s.rd;
        id_RegWrite  = s.rw;
        id_MemRead   = s.mr;
        branch_taken = s.br;
        mem_busy     = s.busy;
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        apply('0);
        rst = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        rst = 1'b0;
        apply(mk_s(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 1, 1));
        exp_q.push_back(mk_e(0,0,0,0, 0,0,1,0, 2'd0, 0, 16'd0));
        exp_q.push_back(mk_e(0,0,0,0, 0,0,1,0, 2'd0, 0, 16'd0));
        exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0, 0, 16'd0));
        #3;
        got_q.push_back(sample());
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        got_q.push_back(sample());
        @(negedge clk); #1;
        apply('0);
        rst = 1'b1;
        @(negedge clk); #1;
        @(posedge clk); #1;
        got_q.push_back(sample());
        for (int i = 0; i < 3; i++) begin
            got = got_q.pop_front();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL reset[%0d]: got %b expected %b", i, got, e);
            else passed++;
        end
    endtask

    task automatic test_forward();
        stim_t s;
        obs_t  got, e;
        int    cyc = 0;
        do_reset();
        stim_q.push_back(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0)); exp_q.push_back(mk_e(1,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd6, 1, 5'd5, 1, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(1,0,0,1, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd6, 0, 5'd6, 1, 5'd0, 1, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,1, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd9, 1, 5'd0, 0, 5'd9, 1, 0, 0, 0)); exp_q.push_back(mk_e(1,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd9, 1, 5'd9, 1, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(1,0,1,0, 0,0,0,0, 2'd0,0,16'd0));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); #1;
            apply(s);
            @(posedge clk); #1;
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL forward[%0d]: got %b expected %b", cyc, got, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_load_use();
        stim_t s;
        obs_t  got, e;
        int    cyc = 0;
        do_reset();
        stim_q.push_back(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd2, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 1,0,1,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd2, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,1, 0,0,0,0, 2'd1,0,16'd1));
        stim_q.push_back(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd1));
        stim_q.push_back(mk_s(0, 5'd0, 0, 5'd7, 1, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); #1;
            apply(s);
            @(posedge clk); #1;
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL load_use[%0d]: got %b expected %b", cyc, got, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_back_to_back_branch();
        stim_t s;
        obs_t  got, e;
        int    cyc = 0;
        do_reset();
        stim_q.push_back(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd7, 1, 5'd0, 0, 5'd3, 1, 0, 1, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,1,1,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd7, 1, 5'd0, 0, 5'd3, 1, 0, 1, 0)); exp_q.push_back(mk_e(0,1,0,0, 0,1,1,0, 2'd2,0,16'd1));
        stim_q.push_back(mk_s(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd2,0,16'd2));
        stim_q.push_back(mk_s(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd2));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); #1;
            apply(s);
            @(posedge clk); #1;
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL branch[%0d]: got %b expected %b", cyc, got, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_memwait();
        stim_t s;
        obs_t  got, e;
        int    cyc = 0;
        do_reset();
        stim_q.push_back(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1)); exp_q.push_back(mk_e(1,0,0,0, 0,0,0,1, 2'd0,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 1, 1)); exp_q.push_back(mk_e(1,0,0,0, 0,0,0,1, 2'd3,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 1, 1)); exp_q.push_back(mk_e(1,0,0,0, 0,0,0,1, 2'd3,0,16'd0));
        stim_q.push_back(mk_s(1, 5'd4, 1, 5'd0, 0, 5'd5, 1, 0, 1, 0)); exp_q.push_back(mk_e(1,0,0,0, 0,1,1,0, 2'd3,0,16'd0));
        stim_q.push_back(mk_s(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd2,0,16'd1));
        stim_q.push_back(mk_s(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0)); exp_q.push_back(mk_e(0,0,0,0, 0,0,0,0, 2'd0,0,16'd1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); #1;
            apply(s);
            @(posedge clk); #1;
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL memwait[%0d]: got %b expected %b", cyc, got, e);
            else passed++;
            cyc++;
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        obs_t  got, e;
        int    cyc = 0;
        do_reset();
        for (int k = 0; k < 263; k++) begin
            stim_q.push_back(mk_s(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, (k < 260)));
            exp_q.push_back(mk_e(0,0,0,0, 0,0,0, (k < 260),
                                 ((k >= 1) && (k <= 260)) ? 2'd3 : 2'd0,
                                 (k >= 255), 16'd0));
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            @(negedge clk); #1;
            apply(s);
            @(posedge clk); #1;
            got = sample();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL timeout[%0d]: got %b expected %b", cyc, got, e);
            else passed++;
            cyc++;
        end
    endtask

    // Runs straight after test_timeout, so mem_timeout is still sticky on entry
    task automatic test_reset_abort();
        obs_t got, e;
        @(negedge clk); #1;
        apply(mk_s(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1));
        @(negedge clk); #1;
        @(posedge clk); #1;
        exp_q.push_back(mk_e(0,0,0,0, 0,0,0,1, 2'd3, 1, 16'd0));
        got_q.push_back(sample());
        rst = 1'b0;
        #1;
        exp_q.push_back(mk_e(0,0,0,0, 0,0,1,0, 2'd0, 0, 16'd0));
        got_q.push_back(sample());
        apply('0);
        @(negedge clk); #1;
        rst = 1'b1;
        apply(mk_s(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 1, 0, 0));
        @(negedge clk); #1;
        apply(mk_s(1, 5'd0, 0, 5'd7, 1, 5'd1, 1, 0, 0, 0));
        @(negedge clk); #1;
        @(posedge clk); #1;
        exp_q.push_back(mk_e(0,0,0,1, 0,0,0,0, 2'd1, 0, 16'd1));
        got_q.push_back(sample());
        rst = 1'b0;
        #1;
        exp_q.push_back(mk_e(0,0,0,0, 0,0,1,0, 2'd0, 0, 16'd0));
        got_q.push_back(sample());
        apply('0);
        @(negedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = got_q.pop_front();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL reset_abort[%0d]: got %b expected %b", i, got, e);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_back_to_back_branch();
        test_memwait();
        test_timeout();
        test_reset_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-002 clk  in  1  pipeline clock; all state SHALL update on the falling edge, the same edge as the ID/EX buffer.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_rs1, id_rs2  in  5 each  source register numbers.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  instruction reads that source.
REQ-007 id_rd  in  5  destination register.
REQ-008 id_RegWrite, id_MemRead  in  1 each  ID control bits.
REQ-009 branch_taken  in  1  EX-stage redirect this cycle.
REQ-010 mem_busy  in  1  data memory not ready.
REQ-011 fwd_ex_1, fwd_mem_1, fwd_ex_2, fwd_mem_2  out  1 each  operand forward selects to the ID/EX buffer.
REQ-012 stall_if  out  1  hold PC and IF/ID.
REQ-013 flush_if  out  1  invalidate IF/ID.
REQ-014 clear_id  out  1  insert a bubble into the ID/EX buffer.
REQ-015 freeze  out  1  hold all pipeline registers.
REQ-016 state  out  2  current FSM state.
REQ-017 bubble_cnt  out  16  saturating count of inserted bubbles.
REQ-018 mem_timeout  out  1  sticky memory-wait watchdog error.

Function
REQ-019 The block SHALL keep shadow registers ex_rd/ex_RegWrite/ex_MemRead and mem_rd/mem_RegWrite that mirror the EX and MEM stages.
REQ-020 When freeze=0, each falling edge SHALL load ex_* from the id_* inputs; ex_* SHALL load 0 when clear_id=1 or id_valid=0.
REQ-021 When freeze=0, each falling edge SHALL load mem_* from ex_*.
REQ-022 When freeze=1, all shadow registers SHALL hold.
REQ-023 fwd_ex_k SHALL be combinational and equal: id_use_rsk AND rsk!=0 AND ex_RegWrite AND !ex_MemRead AND ex_rd==rsk.
REQ-024 fwd_mem_k SHALL equal: id_use_rsk AND rsk!=0 AND mem_RegWrite AND mem_rd==rsk AND !fwd_ex_k (EX has priority).
REQ-025 A load-use hazard SHALL be detected when id_valid AND ex_MemRead AND ex_rd!=0 AND ex_rd matches a used source.
REQ-026 On a load-use hazard, stall_if=1 and clear_id=1 SHALL be asserted combinationally for one cycle; the FSM SHALL move to LDSTALL for that one cycle, then return to RUN.
REQ-027 branch_taken=1 SHALL assert flush_if=1 and clear_id=1 for that cycle and force stall_if=0; the FSM SHALL go to FLUSH for one cycle.
REQ-028 branch_taken SHALL take priority over a load-use hazard raised in the same cycle.
REQ-029 mem_busy=1 SHALL assert freeze=1 and suppress stall_if, flush_if and clear_id; the FSM SHALL be in MEMWAIT while mem_busy=1 and return to RUN on the first edge with mem_busy=0.
REQ-030 mem_busy SHALL take priority over both the branch and load-use cases; a branch_taken held during MEMWAIT SHALL be acted on in the first cycle after release.
REQ-031 FSM encoding SHALL be: RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3.
REQ-032 bubble_cnt SHALL increment by 1 on each edge where clear_id=1, and SHALL saturate at 0xFFFF.
REQ-033 An 8-bit wait counter SHALL count consecutive MEMWAIT cycles and clear on exit; mem_timeout SHALL set when it reaches 255 and stay set until reset.

Reset
REQ-034 While rst=0, all shadow registers, the counters and mem_timeout SHALL be 0, state SHALL be RUN, and the registered outputs SHALL be 0.
REQ-035 While rst=0, clear_id SHALL be 1 and all other combinational outputs SHALL be 0, regardless of the other inputs.
REQ-036 A reset asserted mid-MEMWAIT or mid-LDSTALL SHALL abort it immediately.

Structure
REQ-037 The state encoding, the watchdog limit (255) and the counter widths SHALL live in the shared package pipe_pkg.
REQ-038 Forwarding compare logic SHALL be a sub-module fwd_match, instantiated once per source operand.

Verification
REQ-039 ex_rd=5, ex_RegWrite=1, ex_MemRead=0, id_rs1=5, id_use_rs1=1 -> fwd_ex_1=1, fwd_mem_1=0.
REQ-040 Load into x7 followed by an instruction using rs2=x7 -> one cycle with stall_if=1 and clear_id=1, state=LDSTALL, bubble_cnt=1; next cycle fwd_mem_2=1.
REQ-041 branch_taken and a load-use hazard in the same cycle -> flush_if=1, clear_id=1, stall_if=0, state=FLUSH.
REQ-042 mem_busy held for 3 cycles -> freeze=1 for 3 cycles, shadow registers unchanged, state returns to RUN on the 4th edge.
REQ-043 mem_busy held for 260 cycles -> mem_timeout=1 after 255 cycles and stays 1 after mem_busy falls.
REQ-044 Instruction with rs1=x0 and ex_rd=0, ex_RegWrite=1 -> no forwarding and no stall.
